// File: rtl/gf180mcu_fd_sc_mcu9t5v0__buf_pipe_if.sv
// Valid/ready bus for the elastic buffer.
// Producer side: I, I_VALID in; I_READY back.
// Consumer side: Z, Z_VALID out; Z_READY back.
// COUNT reports the buffer occupancy (0..DEPTH).
// Modports:
//   slave  - the buffer itself
//   master - the environment (producer and consumer) driving the buffer
interface gf180mcu_fd_sc_mcu9t5v0__buf_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             I;
  logic                         I_VALID;
  logic                         I_READY;
  logic [WIDTH-1:0]             Z;
  logic                         Z_VALID;
  logic                         Z_READY;
  logic [$clog2(DEPTH+1)-1:0]   COUNT;

  modport slave (
    input  I, I_VALID, Z_READY,
    output I_READY, Z, Z_VALID, COUNT
  );

  modport master (
    output I, I_VALID, Z_READY,
    input  I_READY, Z, Z_VALID, COUNT
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__buf_pipe.sv
// Elastic multi-bit buffer: a DEPTH-entry FIFO with valid/ready flow control.
// Used to retime and decouple long or heavily loaded nets on one clock domain.
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RST  - synchronous active-high reset
//   bus  - slave side of the buffer bus (I/I_VALID/I_READY, Z/Z_VALID/Z_READY,
//          COUNT occupancy)
// Z is read straight out of the storage registers; there is no bypass, so
// data pushed at one edge is visible on Z after that edge.
module gf180mcu_fd_sc_mcu9t5v0__buf_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RST,
  gf180mcu_fd_sc_mcu9t5v0__buf_pipe_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Flow control is a function of occupancy only, so I_READY never depends
  // on Z_READY: a full buffer refuses a push even while it is being popped.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.I_VALID && !full;
  assign pop   = bus.Z_READY && !empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Only entry 0 is cleared: after reset the read pointer sits on it, which
  // keeps Z free of X while the buffer is empty. Other entries are only ever
  // written by an accepted push, so X on I with I_VALID low never gets in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem[0] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.I;
    end
  end

  assign bus.Z       = mem[rd_ptr];
  assign bus.Z_VALID = !empty;
  assign bus.I_READY = !full;
  assign bus.COUNT   = count;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__buf_pipe.md
Name: gf180mcu_fd_sc_mcu9t5v0__buf_pipe

Overview:
- Parametrised, clocked successor to the combinational buffer cell: an elastic, multi-bit buffer that carries data I to Z through a DEPTH-entry queue with valid/ready flow control.
- Used to retime and decouple long or heavily loaded nets between a producer and a consumer on one clock domain.
- Z is driven from a register. No combinational path runs from I to Z.

Parameters:
- WIDTH, 8, data width of I and Z in bits (≥1).
- DEPTH, 4, number of storage entries; power of two, ≥2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- I  input  WIDTH  write data.
- I_VALID  input  1  producer offers I this cycle.
- I_READY  output  1  buffer can accept; I_READY = !full.
- Z  output  WIDTH  read data (head entry).
- Z_VALID  output  1  Z holds valid data; Z_VALID = !empty.
- Z_READY  input  1  consumer takes Z this cycle.
- COUNT  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Push: when I_VALID && I_READY at a rising edge, I is written to the tail entry.
- Pop: when Z_VALID && Z_READY at a rising edge, the head entry is removed.
- I_READY depends only on state (full), never on Z_READY. A push is refused when full, even if a pop occurs in the same cycle.
- Z_VALID depends only on state. There is no bypass: data pushed at edge n appears on Z with Z_VALID=1 after edge n. Minimum latency is 1 cycle.
- Z is the head entry whenever Z_VALID=1. Z holds its value stable while Z_VALID && !Z_READY.
- Z value when Z_VALID=0: don't-care for checking, but must not be X after reset. Reset clears storage entry 0 to 0.
- Storage: DEPTH×WIDTH register array, read pointer and write pointer of clog2(DEPTH) bits each. Pointers wrap modulo DEPTH (DEPTH-1 → 0).
- COUNT is a registered counter:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- full = (COUNT==DEPTH); empty = (COUNT==0).
- Simultaneous push and pop with 0<COUNT<DEPTH: both pointers advance and COUNT is unchanged. Ordering is strictly FIFO.
- Push and pop together at COUNT==0 is impossible, because Z_VALID=0 at that count.
- I_VALID while full: no write, no pointer change. The producer must hold I and I_VALID until I_READY; the block does not check this.
- Z_READY while empty: ignored.
- Reset:
  - RST=1 at a rising edge forces read pointer, write pointer and COUNT to 0, giving I_READY=1, Z_VALID=0, COUNT=0 after that edge.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-operation discards all stored entries.
- Before the first reset edge, outputs are undefined. The bench must apply reset for at least 1 cycle.
- No X propagation from I when I_VALID=0: storage is written only on an accepted push.

Test Plan:
- Reset: RST=1 for 2 cycles with I_VALID=1, Z_READY=1 → after reset COUNT=0, I_READY=1, Z_VALID=0, and nothing was written.
- Single transfer: push 0xA5 at edge n with Z_READY=0 → Z_VALID=1, Z=0xA5, COUNT=1 after edge n. Assert Z_READY → Z_VALID=0, COUNT=0 after the next edge.
- Fill, then back-pressure (DEPTH=4): push 0x01..0x04 with Z_READY=0 → I_READY=0 and COUNT=4. Push 0x05 while I_VALID=1 → refused (COUNT stays 4). Drain → Z reads 0x01,0x02,0x03,0x04 in order, then Z_VALID=0.
- Full with simultaneous pop: at COUNT=4 hold I_VALID=1 and Z_READY=1 for one edge → pop occurs, push refused, COUNT=3. On the next edge the push is accepted and COUNT=4.
- Streaming and wrap: I_VALID=1 and Z_READY=1 continuously for 20 cycles with incrementing data 0..19 → steady state COUNT=1, output sequence 0..19 in order, pointers wrap at least 4 times with no loss or duplication.
- Reset mid-operation: at COUNT=3 assert RST for one edge while pushing 0x77 → COUNT=0, Z_VALID=0. The next push of 0x11 → Z=0x11, and the old data never reappears.
